// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver.
// Parity modes, receiver states, frame status bundle, vote helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic break_det;
  } rx_status_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, falling-edge detect and 3-sample majority vote.
// The third vote sample is the live synchronised value.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic sample_en,
  output logic rx_sync,
  output logic fall,
  output logic vote
);
  import uart_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [1:0]             samp_q;

  // Synchroniser chain, edge history and the two early vote samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      samp_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (sample_en) begin
        samp_q <= {samp_q[0], sync_q[SYNC_STAGES-1]};
      end
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];
  assign fall    = prev_q & ~rx_sync;
  assign vote    = maj3(samp_q[1], samp_q[0], rx_sync);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled FSM, error status,
// valid/ready delivery with sticky overrun.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 busy
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_HI   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  rx_state_e state, state_nx;

  logic [TW-1:0]        tick, tick_nx;
  logic [BW-1:0]        bit_cnt, bit_cnt_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 par_bit, par_bit_nx;
  logic                 stop_idx, stop_idx_nx;
  logic                 stop_bad, stop_bad_nx;
  logic                 stop_one, stop_one_nx;
  logic                 done, done_nx;
  rx_status_t           pend_st, pend_st_nx;

  logic rx_sync;
  logic fall;
  logic vote;
  logic active;
  logic sample_en;
  logic maj_pt;
  logic end_bit;
  logic par_exp;
  logic hs;

  assign active    = (state != IDLE) && (state != WAIT_IDLE);
  assign sample_en = active && baud_tick &&
                     ((tick == T_LO) || (tick == T_MID));
  assign maj_pt    = active && baud_tick && (tick == T_HI);
  assign end_bit   = active && baud_tick && (tick == T_LAST);
  assign busy      = (state != IDLE);
  assign hs        = data_valid && data_ready;

  assign par_exp = (PARITY == PARITY_ODD) ? ~(^shreg) : (^shreg);

  uart_rx_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .sample_en(sample_en),
    .rx_sync  (rx_sync),
    .fall     (fall),
    .vote     (vote)
  );

  // Receiver state, counters and frame capture registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_idx <= 1'b0;
      stop_bad <= 1'b0;
      stop_one <= 1'b0;
      done     <= 1'b0;
      pend_st  <= '0;
    end else begin
      state    <= state_nx;
      tick     <= tick_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      par_bit  <= par_bit_nx;
      stop_idx <= stop_idx_nx;
      stop_bad <= stop_bad_nx;
      stop_one <= stop_one_nx;
      done     <= done_nx;
      pend_st  <= pend_st_nx;
    end
  end

  // Next-state logic: bit timing, shifting and frame completion.
  always_comb begin
    state_nx    = state;
    tick_nx     = tick;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    par_bit_nx  = par_bit;
    stop_idx_nx = stop_idx;
    stop_bad_nx = stop_bad;
    stop_one_nx = stop_one;
    done_nx     = 1'b0;
    pend_st_nx  = pend_st;

    if (active && baud_tick) begin
      tick_nx = end_bit ? '0 : tick + TW'(1);
    end

    unique case (state)
      IDLE: begin
        if (fall) begin
          state_nx    = START;
          tick_nx     = '0;
          bit_cnt_nx  = '0;
          par_bit_nx  = 1'b0;
          stop_idx_nx = 1'b0;
          stop_bad_nx = 1'b0;
          stop_one_nx = 1'b0;
        end
      end
      START: begin
        if (maj_pt && vote) begin
          state_nx = IDLE;
          tick_nx  = '0;
        end else if (end_bit) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (maj_pt) begin
          shreg_nx   = {vote, shreg[DATA_BITS-1:1]};
          bit_cnt_nx = bit_cnt + BW'(1);
        end
        if (end_bit && (bit_cnt == B_LAST)) begin
          state_nx = (PARITY != PARITY_NONE) ?
                     uart_pkg::PARITY : STOP;
        end
      end
      uart_pkg::PARITY: begin
        if (maj_pt) begin
          par_bit_nx = vote;
        end
        if (end_bit) begin
          state_nx = STOP;
        end
      end
      STOP: begin
        if (maj_pt) begin
          if (stop_idx == S_LAST) begin
            done_nx               = 1'b1;
            pend_st_nx.parity_err = (PARITY != PARITY_NONE) &&
                                    (par_bit != par_exp);
            pend_st_nx.frame_err  = stop_bad | ~vote;
            pend_st_nx.break_det  = ~(|shreg) & ~par_bit &
                                    ~stop_one & ~vote;
            state_nx              = vote ? IDLE : WAIT_IDLE;
            tick_nx               = '0;
          end else begin
            stop_bad_nx = stop_bad | ~vote;
            stop_one_nx = stop_one | vote;
            stop_idx_nx = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output handshake: load a completed frame or flag overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (hs) begin
        data_valid  <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (done) begin
        if (!data_valid || hs) begin
          data_out   <= shreg;
          parity_err <= pend_st.parity_err;
          frame_err  <= pend_st.frame_err;
          break_det  <= pend_st.break_det;
          data_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1 instance
// and a 7E1 instance fed on separate lines.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick = 1'b0;
  logic [1:0] tdiv = 2'd0;
  logic       rx, rx_p;
  logic       data_ready;

  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err;
  logic       break_det, overrun_err, busy;

  logic [6:0] p_data_out;
  logic       p_data_valid, p_parity_err, p_frame_err;
  logic       p_break_det, p_overrun_err, p_busy;

  int nvec = 0;
  int nerr = 0;

  int         cnt = 0;
  logic [7:0] got_data = '0;
  logic [2:0] got_st = '0;
  int         pcnt = 0;
  logic [6:0] pgot_data = '0;
  logic [2:0] pgot_st = '0;

  uart_rx_param dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  uart_rx_param #(
    .DATA_BITS(7),
    .PARITY   (1)
  ) dut_p (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx_p),
    .data_out   (p_data_out),
    .data_valid (p_data_valid),
    .data_ready (1'b1),
    .parity_err (p_parity_err),
    .frame_err  (p_frame_err),
    .break_det  (p_break_det),
    .overrun_err(p_overrun_err),
    .busy       (p_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tdiv      = tdiv + 2'd1;
    baud_tick = (tdiv == 2'd3);
  end

  always @(negedge clk) begin
    if (data_valid && data_ready) begin
      cnt      = cnt + 1;
      got_data = data_out;
      got_st   = {parity_err, frame_err, break_det};
    end
    if (p_data_valid) begin
      pcnt      = pcnt + 1;
      pgot_data = p_data_out;
      pgot_st   = {p_parity_err, p_frame_err, p_break_det};
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec = nvec + 1;
    if (got !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(
    input bit          which,
    input logic [15:0] v,
    input int          n
  );
    for (int i = 0; i < n; i++) begin
      if (which) rx_p = v[i];
      else       rx   = v[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  int c0;

  initial begin
    rst        = 1'b0;
    rx         = 1'b1;
    rx_p       = 1'b1;
    data_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_ovr", 32'(overrun_err), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    c0 = cnt;
    send(0, {6'd0, 1'b1, 8'hB4, 1'b0}, 10);
    chk("b4_cnt", 32'(cnt), 32'(c0 + 1));
    chk("b4_data", 32'(got_data), 32'hB4);
    chk("b4_st", 32'(got_st), 32'd0);
    send(0, {6'd0, 1'b1, 8'hF0, 1'b0}, 10);
    chk("f0_cnt", 32'(cnt), 32'(c0 + 2));
    chk("f0_data", 32'(got_data), 32'hF0);
    chk("f0_st", 32'(got_st), 32'd0);
    chk("f0_valid", 32'(data_valid), 32'd0);

    send(1, {6'd0, 1'b1, 1'b0, 7'h35, 1'b0}, 10);
    chk("p_ok_cnt", 32'(pcnt), 32'd1);
    chk("p_ok_data", 32'(pgot_data), 32'h35);
    chk("p_ok_st", 32'(pgot_st), 32'd0);
    send(1, {6'd0, 1'b1, 1'b1, 7'h35, 1'b0}, 10);
    chk("p_bad_cnt", 32'(pcnt), 32'd2);
    chk("p_bad_data", 32'(pgot_data), 32'h35);
    chk("p_bad_st", 32'(pgot_st), 32'b100);

    c0 = cnt;
    send(0, {6'd0, 1'b0, 8'h5A, 1'b0}, 10);
    chk("fe_cnt", 32'(cnt), 32'(c0 + 1));
    chk("fe_data", 32'(got_data), 32'h5A);
    chk("fe_st", 32'(got_st), 32'b010);
    chk("fe_busy_hold", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("fe_busy_rel", 32'(busy), 32'd0);
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    chk("brk_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    chk("brk_cnt", 32'(cnt), 32'(c0 + 2));
    chk("brk_data", 32'(got_data), 32'h00);
    chk("brk_st", 32'(got_st), 32'b011);
    chk("brk_busy_rel", 32'(busy), 32'd0);

    data_ready = 1'b0;
    send(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    chk("ov1_valid", 32'(data_valid), 32'd1);
    chk("ov1_ovr", 32'(overrun_err), 32'd0);
    send(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
    chk("ov2_valid", 32'(data_valid), 32'd1);
    chk("ov2_data", 32'(data_out), 32'hA5);
    chk("ov2_ovr", 32'(overrun_err), 32'd1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    chk("ov_hs_valid", 32'(data_valid), 32'd0);
    chk("ov_hs_ovr", 32'(overrun_err), 32'd0);
    data_ready = 1'b1;

    c0 = cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("gl_cnt", 32'(cnt), 32'(c0));
    chk("gl_busy", 32'(busy), 32'd0);
    send(0, {6'd0, 1'b1, 8'h81, 1'b0}, 10);
    chk("g81_cnt", 32'(cnt), 32'(c0 + 1));
    chk("g81_data", 32'(got_data), 32'h81);

    c0 = cnt;
    fork
      send(0, {6'd0, 1'b1, 8'h66, 1'b0}, 10);
      begin
        repeat (300) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_valid", 32'(data_valid), 32'd0);
        chk("mr_data", 32'(data_out), 32'd0);
        chk("mr_flags",
            32'({parity_err, frame_err, break_det, overrun_err}),
            32'd0);
      end
    join
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("mr_cnt", 32'(cnt), 32'(c0));
    chk("mr_valid2", 32'(data_valid), 32'd0);
    chk("mr_busy2", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
